// File: rtl/inv_seq_pkg.sv
// Shared types and defaults for the double-inverter test sequencer.
package inv_seq_pkg;

  localparam int DEF_MAX_WAIT = 255;
  localparam int DEF_CNT_W    = 8;

  localparam logic SEL_RISE = 1'b0;
  localparam logic SEL_FALL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESET = 3'd1,
    RISE   = 3'd2,
    FALL   = 3'd3,
    DONE   = 3'd4
  } inv_seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, cleared to 0 by reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inv_test_sequencer.sv
// Drives a stimulus edge into the inverter loop and times how long the
// synchronized return takes to follow, for both the rising and falling edge.
module inv_test_sequencer
  import inv_seq_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sample_in,
  input  logic             sel,
  output logic             stim_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] result
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  inv_seq_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rise_delay;
  logic [CNT_W-1:0] fall_delay;
  logic             start_q;
  logic             smp_s;
  logic             start_edge;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sample_in),
    .q     (smp_s)
  );

  assign start_edge = start & ~start_q;
  assign result     = (sel == SEL_FALL) ? fall_delay : rise_delay;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      start_q    <= 1'b0;
      stim_out   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      rise_delay <= '0;
      fall_delay <= '0;
    end else begin
      start_q <= start;
      // Disabling the tile aborts any measurement but keeps the last results.
      if (!ena) begin
        state    <= IDLE;
        cnt      <= '0;
        stim_out <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_edge) begin
              state      <= PRESET;
              cnt        <= '0;
              busy       <= 1'b1;
              done       <= 1'b0;
              pass       <= 1'b0;
              timeout    <= 1'b0;
              rise_delay <= '0;
              fall_delay <= '0;
            end
          end

          PRESET: begin
            if (!smp_s) begin
              state    <= RISE;
              cnt      <= '0;
              stim_out <= 1'b1;
            end else if (cnt == MAX_CNT) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RISE: begin
            if (smp_s) begin
              state      <= FALL;
              rise_delay <= cnt;
              cnt        <= '0;
              stim_out   <= 1'b0;
            end else if (cnt == MAX_CNT) begin
              state      <= DONE;
              rise_delay <= MAX_CNT;
              stim_out   <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              timeout    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          FALL: begin
            if (!smp_s) begin
              state      <= DONE;
              fall_delay <= cnt;
              busy       <= 1'b0;
              done       <= 1'b1;
              pass       <= 1'b1;
            end else if (cnt == MAX_CNT) begin
              state      <= DONE;
              fall_delay <= MAX_CNT;
              busy       <= 1'b0;
              done       <= 1'b1;
              timeout    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          default: begin
            state    <= IDLE;
            cnt      <= '0;
            stim_out <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inv_test_sequencer.sv
// Randomized loopback/stuck-pin measurements with a queue scoreboard, plus
// directed reset, enable and restart scenarios.
module tb_inv_test_sequencer;

  localparam int MAX_WAIT = 255;
  localparam int CNT_W    = 8;
  localparam int M_LOOP   = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_STUCK1 = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             start = 1'b0;
  logic             sel = 1'b0;
  logic             sample_in;
  logic             stim_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [CNT_W-1:0] result;

  int mode = M_LOOP;
  int dly  = 0;
  logic [31:0] hist = '0;

  typedef struct {
    logic       pass;
    logic       timeout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       stim_hi;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  inv_test_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .sample_in (sample_in),
    .sel       (sel),
    .stim_out  (stim_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .result    (result)
  );

  // Off-chip loop: stim_out delayed by dly whole cycles, or a stuck level.
  always @(posedge clk) hist <= {hist[30:0], stim_out};
  assign sample_in = (mode == M_STUCK1) ? 1'b1 :
                     (mode == M_STUCK0) ? 1'b0 :
                     (dly == 0)         ? stim_out : hist[dly-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Expected outcome from the pin behaviour alone: delay is pad delay + 2.
  function automatic exp_t model(input int m, input int d);
    exp_t e;
    e.pass = 1'b0; e.timeout = 1'b0; e.rise = 8'd0; e.fall = 8'd0; e.stim_hi = 1'b1;
    if (m == M_LOOP) begin
      e.pass = 1'b1;
      e.rise = 8'(d + 2);
      e.fall = 8'(d + 2);
    end else if (m == M_STUCK0) begin
      e.timeout = 1'b1;
      e.rise    = 8'(MAX_WAIT);
    end else begin
      e.timeout = 1'b1;
      e.stim_hi = 1'b0;
    end
    return e;
  endfunction

  // Monitor: pops one expectation per rising done and checks while done holds.
  exp_t cur;
  logic have_cur = 1'b0;
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic stim_seen = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur  = 1'b0;
      done_prev = 1'b0;
      busy_prev = 1'b0;
      stim_seen = 1'b0;
    end else begin
      if (busy && !busy_prev) stim_seen = 1'b0;
      if (stim_out) stim_seen = 1'b1;
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          cur = sb_q.pop_front();
          have_cur = 1'b1;
          check("pass", pass, cur.pass);
          check("timeout", timeout, cur.timeout);
          check("busy_at_done", busy, 1'b0);
          check("stim_at_done", stim_out, 1'b0);
          check("stim_went_high", stim_seen, cur.stim_hi);
        end
      end
      if (done && have_cur) begin
        if (sel) check("fall_delay", result, cur.fall);
        else     check("rise_delay", result, cur.rise);
      end
      if (!done) have_cur = 1'b0;
      done_prev = done;
      busy_prev = busy;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_stim(input logic lvl, input string name);
    int n = 0;
    while (stim_out !== lvl && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, stim_out, lvl);
  endtask

  task automatic run_txn(input int m, input int d, input bit extra);
    int n = 0;
    mode = m;
    dly  = d;
    repeat (25) @(posedge clk);
    #1 sel = 1'b0;
    sb_q.push_back(model(m, d));
    pulse_start();
    check("start_sets_busy", busy, 1'b1);
    check("start_clears_done", done, 1'b0);
    if (extra) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    while (!done && n < 700) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      check("done_wait", 32'd0, 32'd1);
      void'(sb_q.pop_back());
    end else begin
      sel = 1'b0;
      repeat (2) @(posedge clk);
      #1 sel = 1'b1;
      repeat (2) @(posedge clk);
      #1 sel = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_stim", stim_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;

    run_txn(M_LOOP, 0, 1'b0);
    run_txn(M_LOOP, 5, 1'b0);
    run_txn(M_STUCK0, 0, 1'b0);
    run_txn(M_STUCK1, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int  m;
      int  d;
      bit  ex;
      m  = ($urandom_range(0, 9) < 8) ? M_LOOP : int'($urandom_range(1, 2));
      d  = int'($urandom_range(0, 20));
      ex = 1'($urandom_range(0, 1));
      if (ex && d < 3) d = 3;
      run_txn(m, d, ex);
    end

    // Reset pulse in the middle of RISE.
    mode = M_LOOP;
    dly  = 15;
    repeat (25) @(posedge clk);
    pulse_start();
    wait_stim(1'b1, "rise_entered");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stim", stim_out, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_timeout", timeout, 1'b0);
    sel = 1'b1;
    #1 check("midrst_result_fall", result, 32'd0);
    sel = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_txn(M_LOOP, 0, 1'b0);

    // ena dropped during FALL: abort to idle, rise result kept.
    mode = M_LOOP;
    dly  = 10;
    repeat (25) @(posedge clk);
    pulse_start();
    wait_stim(1'b1, "rise_entered");
    wait_stim(1'b0, "fall_entered");
    @(posedge clk); #1 ena = 1'b0;
    @(posedge clk); #1;
    check("ena_busy", busy, 1'b0);
    check("ena_stim", stim_out, 1'b0);
    check("ena_done", done, 1'b0);
    sel = 1'b0;
    #1 check("ena_rise_held", result, 32'd12);
    sel = 1'b1;
    #1 check("ena_fall_held", result, 32'd0);
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("ena_stays_idle", busy, 1'b0);
    ena = 1'b1;

    run_txn(M_LOOP, 3, 1'b1);
    run_txn(M_LOOP, 7, 1'b0);

    repeat (5) @(posedge clk);
    #1 check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
